fsm_stim_driver: RTL and testbench
==================================

FSM_STIM_DRIVER -- requirements
Module: fsm_stim_driver

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8: width of the stimulus bus driven into the FSM under test.
REQ-002 SHALL have parameter OUT_WIDTH, default 4: width of the response bus returned from the FSM under test.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the vector count.
REQ-004 SHALL have parameter TAPS, IN_WIDTH bits, default 8'hB8: stimulus LFSR feedback mask.
REQ-005 SHALL have parameter SIG_TAPS, 16 bits, default 16'hB400: response MISR feedback mask.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1 bit: one-cycle request to begin a run.
REQ-009 SHALL have port num_vectors, input, CNT_WIDTH bits: vectors per run, sampled when start is accepted.
REQ-010 SHALL have port seed, input, IN_WIDTH bits: LFSR seed, sampled when start is accepted.
REQ-011 SHALL have port stim_out, output, IN_WIDTH bits: drives the FSM's in_signal.
REQ-012 SHALL have port dut_rst_n, output, 1 bit: drives the FSM's active-low rst_n.
REQ-013 SHALL have port resp_in, input, OUT_WIDTH bits: the FSM's out_signal.
REQ-014 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a run.
REQ-016 SHALL have port signature, output, 16 bits: MISR result of the last run.
REQ-017 SHALL have port vec_idx, output, CNT_WIDTH bits: index of the vector currently applied.

Function
REQ-018 SHALL implement the FSM states IDLE, DUT_RST, RUN and DONE.
REQ-019 SHALL, in IDLE with start=1 and num_vectors!=0, go to DUT_RST and on that edge:
- latch num_vectors;
- load the LFSR with seed, or with 1 if seed==0;
- clear signature and vec_idx.
REQ-020 SHALL, in IDLE with start=1 and num_vectors==0, go directly to DONE and clear signature to 0.
REQ-021 SHALL hold DUT_RST for exactly 2 cycles with dut_rst_n=0, then go to RUN.
REQ-022 SHALL drive dut_rst_n=1 in every state other than DUT_RST and during rst.
REQ-023 SHALL, in RUN, drive stim_out = LFSR and apply one vector per cycle.
REQ-024 SHALL, at each RUN edge, update the LFSR as next = {lfsr[IN_WIDTH-2:0], ^(lfsr & TAPS)}.
REQ-025 SHALL, at each RUN edge, update the signature as sig_next = {sig[14:0], ^(sig & SIG_TAPS)} XOR zero-extended resp_in, sampling resp_in in the same cycle as the stim_out it answers.
REQ-026 SHALL, at each RUN edge, increment vec_idx.
REQ-027 SHALL remain in RUN for exactly the latched num_vectors cycles, then go to DONE.
REQ-028 SHALL drive stim_out=0 outside RUN.
REQ-029 SHALL make DONE last one cycle with done=1, then return to IDLE.
REQ-030 SHALL hold signature and vec_idx stable from DONE until the next accepted start.
REQ-031 SHALL drive busy=1 in DUT_RST and RUN, and busy=0 in IDLE and DONE.
REQ-032 SHALL ignore start whenever the FSM is not in IDLE, including in DONE.
REQ-033 SHALL ignore changes on num_vectors and seed after start has been accepted.
REQ-034 SHALL treat num_vectors = 2^CNT_WIDTH-1 as a normal run; the vector counter does not wrap.

Reset
REQ-035 SHALL, with rst=1 at an edge, set state=IDLE, stim_out=0, dut_rst_n=0 during rst, busy=0, done=0, signature=0, vec_idx=0 and LFSR=1.
REQ-036 SHALL abort a run in progress when rst asserts mid-run, with no done pulse, and come out of reset in IDLE.

Verification
REQ-037 SHALL cover: seed=8'h01, num_vectors=5 -> dut_rst_n low for 2 cycles, then stim_out = 01, 02, 04, 08, 11 on consecutive cycles, done pulses the cycle after 11, busy high for 7 cycles.
REQ-038 SHALL cover: resp_in held at 4'h1, num_vectors=3 -> signature=16'h0007; with resp_in held at 0 -> signature=16'h0000.
REQ-039 SHALL cover: seed=0, num_vectors=2 -> stim_out = 01, 02.
REQ-040 SHALL cover: num_vectors=0 -> done the cycle after start, busy never high, dut_rst_n stays 1, signature=0.
REQ-041 SHALL cover: start pulsed during RUN and during DONE -> ignored, run length and signature unchanged.
REQ-042 SHALL cover: rst asserted at the 3rd RUN cycle -> next cycle state=IDLE, stim_out=0, busy=0, no done pulse; a following run with seed=8'h01 reproduces the results of REQ-037.

Source files
------------

// File: rtl/fsm_stim_driver.sv
// Stimulus driver for an FSM under test: resets it, plays an LFSR vector
// sequence into it and compacts its responses into a 16-bit MISR signature.
//
// state   | meaning
// IDLE    | waiting for start
// DUT_RST | holding the FSM under test in reset for two cycles
// RUN     | applying one LFSR vector per cycle, folding responses into the MISR
// DONE    | one-cycle done pulse, results held
module fsm_stim_driver #(
  parameter int                  IN_WIDTH  = 8,
  parameter int                  OUT_WIDTH = 4,
  parameter int                  CNT_WIDTH = 16,
  parameter logic [IN_WIDTH-1:0] TAPS      = 8'hB8,
  parameter logic [15:0]         SIG_TAPS  = 16'hB400
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_vectors,
  input  logic [IN_WIDTH-1:0]  seed,
  output logic [IN_WIDTH-1:0]  stim_out,
  output logic                 dut_rst_n,
  input  logic [OUT_WIDTH-1:0] resp_in,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          signature,
  output logic [CNT_WIDTH-1:0] vec_idx
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DUT_RST = 2'd1,
    S_RUN     = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IN_WIDTH-1:0]  r_lfsr;
  logic [15:0]          r_sig;
  logic [CNT_WIDTH-1:0] r_vec_idx;
  logic [CNT_WIDTH-1:0] r_num;
  logic                 r_rst_cnt;

  logic [CNT_WIDTH-1:0] w_vec_inc;
  logic                 w_last_vec;
  logic [IN_WIDTH-1:0]  w_lfsr_nxt;
  logic [15:0]          w_sig_nxt;

  assign w_vec_inc  = r_vec_idx + CNT_WIDTH'(1);
  // r_num is never zero in RUN, so the counter tops out at r_num and never wraps
  assign w_last_vec = (w_vec_inc == r_num);
  assign w_lfsr_nxt = {r_lfsr[IN_WIDTH-2:0], ^(r_lfsr & TAPS)};
  assign w_sig_nxt  = {r_sig[14:0], ^(r_sig & SIG_TAPS)} ^ 16'(resp_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (num_vectors != '0) ? S_DUT_RST : S_DONE;
        end
      end
      S_DUT_RST: begin
        if (r_rst_cnt) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_vec) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr    <= IN_WIDTH'(1);
      r_sig     <= '0;
      r_vec_idx <= '0;
      r_num     <= '0;
      r_rst_cnt <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sig <= '0;
            if (num_vectors != '0) begin
              r_num     <= num_vectors;
              r_lfsr    <= (seed == '0) ? IN_WIDTH'(1) : seed;
              r_vec_idx <= '0;
              r_rst_cnt <= 1'b0;
            end
          end
        end
        S_DUT_RST: begin
          r_rst_cnt <= ~r_rst_cnt;
        end
        S_RUN: begin
          r_lfsr    <= w_lfsr_nxt;
          r_sig     <= w_sig_nxt;
          r_vec_idx <= w_vec_inc;
        end
        default: begin
        end
      endcase
    end
  end

  assign stim_out  = (r_state == S_RUN) ? r_lfsr : '0;
  assign dut_rst_n = ~rst & (r_state != S_DUT_RST);
  assign busy      = (r_state == S_DUT_RST) || (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign signature = r_sig;
  assign vec_idx   = r_vec_idx;

endmodule

// File: tb/tb_fsm_stim_driver.sv
// Bench for fsm_stim_driver: per-cycle comparison against a phase-count model
// plus literal expectations for the directed scenarios.
module tb_fsm_stim_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_vectors = '0;
  logic [7:0]  seed = '0;
  logic [7:0]  stim_out;
  logic        dut_rst_n;
  logic [3:0]  resp_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [15:0] vec_idx;

  int checks = 0;
  int errors = 0;

  fsm_stim_driver dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_vectors(num_vectors),
    .seed       (seed),
    .stim_out   (stim_out),
    .dut_rst_n  (dut_rst_n),
    .resp_in    (resp_in),
    .busy       (busy),
    .done       (done),
    .signature  (signature),
    .vec_idx    (vec_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [3:0] r);
    return {s[14:0], ^(s & 16'hB400)} ^ {12'h000, r};
  endfunction

  // Model: a run is described by the number of cycles since start was accepted;
  // cycles 0-1 hold the target in reset, the next n cycles apply vectors.
  bit          m_seen_rst = 0;
  bit          m_active = 0;
  bit          m_done = 0;
  int          m_t = 0;
  int          m_n = 0;
  int          m_k = 0;
  logic [7:0]  m_lfsr = 8'h01;
  logic [15:0] m_sig = '0;
  logic [15:0] m_vec = '0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_n_during_rst", {31'b0, dut_rst_n}, 32'd0);
      m_seen_rst = 1;
      m_active   = 0;
      m_done     = 0;
      m_sig      = '0;
      m_vec      = '0;
    end else if (m_seen_rst) begin
      chk("stim_out",  {24'b0, stim_out},  {24'b0, (m_active && m_t >= 2) ? m_lfsr : 8'h00});
      chk("busy",      {31'b0, busy},      {31'b0, m_active});
      chk("done",      {31'b0, done},      {31'b0, m_done});
      chk("dut_rst_n", {31'b0, dut_rst_n}, {31'b0, !(m_active && m_t < 2)});
      chk("signature", {16'b0, signature}, {16'b0, m_sig});
      chk("vec_idx",   {16'b0, vec_idx},   {16'b0, m_vec});
      if (m_done) begin
        m_done = 0;
      end else if (!m_active) begin
        if (start) begin
          m_sig = '0;
          if (num_vectors == 0) begin
            m_done = 1;
          end else begin
            m_active = 1;
            m_t      = 0;
            m_k      = 0;
            m_n      = num_vectors;
            m_lfsr   = (seed == 0) ? 8'h01 : seed;
            m_vec    = '0;
          end
        end
      end else begin
        if (m_t >= 2) begin
          m_sig  = misr_step(m_sig, resp_in);
          m_lfsr = lfsr_step(m_lfsr);
          m_k++;
          m_vec  = 16'(m_k);
          if (m_k == m_n) begin
            m_active = 0;
            m_done   = 1;
          end
        end
        m_t++;
      end
    end
  end

  logic [7:0] obs_stim[$];
  int         busy_cnt, rlow_cnt, done_k;

  // Starts one run; k counts cycles after the accepting edge (DONE is k = 2+n).
  task automatic do_run(input int n, input logic [7:0] sd, input int rmode,
                        input int start_at, input int rst_at);
    int budget;
    budget   = n + 12;
    busy_cnt = 0;
    rlow_cnt = 0;
    done_k   = -1;
    obs_stim.delete();
    @(posedge clk); #1;
    start       = 1'b1;
    num_vectors = 16'(n);
    seed        = sd;
    resp_in     = (rmode == 2) ? 4'($urandom) : 4'(rmode);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      start       = (k == start_at);
      rst         = (k == rst_at);
      num_vectors = 16'($urandom);
      seed        = 8'($urandom);
      resp_in     = (rmode == 2) ? 4'($urandom) : 4'(rmode);
      @(negedge clk);
      if (busy) busy_cnt++;
      if (!dut_rst_n && !rst) rlow_cnt++;
      if (busy && dut_rst_n && !rst) obs_stim.push_back(stim_out);
      if (done && done_k < 0) done_k = k;
      if (done || (rst_at >= 0 && k == rst_at + 1)) break;
    end
    if (rst_at < 0 && done_k < 0) chk("run_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic chk_stim(input string nm, input logic [7:0] exp[$]);
    chk({nm, "_len"}, obs_stim.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs_stim.size(); i++)
      chk(nm, {24'b0, obs_stim[i]}, {24'b0, exp[i]});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_sig", {16'b0, signature}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);

    // seed 01, five vectors
    do_run(5, 8'h01, 2, -1, -1);
    chk_stim("seq_seed01", '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11});
    chk("busy_cycles_5", busy_cnt, 32'd7);
    chk("rstn_low_5", rlow_cnt, 32'd2);
    chk("done_k_5", done_k, 32'd7);

    do_run(3, 8'h3C, 1, -1, -1);
    chk("sig_resp1", {16'b0, signature}, 32'h0007);
    chk("vec_idx_3", {16'b0, vec_idx}, 32'd3);
    do_run(3, 8'h3C, 0, -1, -1);
    chk("sig_resp0", {16'b0, signature}, 32'h0000);

    do_run(2, 8'h00, 2, -1, -1);
    chk_stim("seq_seed00", '{8'h01, 8'h02});

    do_run(0, 8'h55, 2, -1, -1);
    chk("zero_busy", busy_cnt, 32'd0);
    chk("zero_rstn", rlow_cnt, 32'd0);
    chk("zero_done_k", done_k, 32'd0);
    chk("zero_sig", {16'b0, signature}, 32'd0);

    // start pulses in RUN and in DONE must be ignored
    do_run(6, 8'h5A, 1, 4, -1);
    chk("inj_run_busy", busy_cnt, 32'd8);
    chk("inj_run_sig", {16'b0, signature}, 32'h003F);
    do_run(6, 8'h5A, 1, 8, -1);
    chk("inj_done_busy", busy_cnt, 32'd8);
    chk("inj_done_sig", {16'b0, signature}, 32'h003F);
    repeat (2) @(negedge clk);
    chk("inj_done_idle", {31'b0, busy}, 32'd0);

    // reset on the third RUN cycle (k = 4)
    do_run(8, 8'h01, 2, -1, 4);
    chk("abort_no_done", done_k, 32'hFFFF_FFFF);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_stim", {24'b0, stim_out}, 32'd0);
    do_run(5, 8'h01, 2, -1, -1);
    chk_stim("seq_after_abort", '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11});
    chk("busy_after_abort", busy_cnt, 32'd7);

    for (int r = 0; r < 15; r++) begin
      int n, sa;
      n  = $urandom_range(0, 40);
      sa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n + 2) : -1;
      do_run(n, 8'($urandom), 2, sa, -1);
      chk("rand_busy", busy_cnt, (n == 0) ? 0 : n + 2);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    do_run(1000, 8'($urandom), 2, -1, -1);
    chk("long_vec_idx", {16'b0, vec_idx}, 32'd1000);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
